ram_master: RTL

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master_if.sv | 32 +++
 rtl/ram_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram_master_if.sv
// Bus bundle shared by a burst requester, the ram_master and a single-port RAM.
// Handshake: req is taken only while busy=0; wdata must be valid while wdata_rdy=1 and is taken on that cycle's closing edge; rvalid and done are single-cycle strobes with no back-pressure.
interface ram_master_if #(
    parameter int addr_size = 4,
    parameter int word_size = 8
);
    logic                 req;
    logic                 req_wr;
    logic [addr_size-1:0] req_addr;
    logic [addr_size-1:0] req_len;
    logic [word_size-1:0] wdata;
    logic                 wdata_rdy;
    logic [word_size-1:0] rdata;
    logic                 rvalid;
    logic                 busy;
    logic                 done;
    logic [addr_size-1:0] addr;
    logic [word_size-1:0] data_out;
    logic [word_size-1:0] data_in;
    logic                 wr;
    logic                 cs;

    modport master (
        input  req, req_wr, req_addr, req_len, wdata, data_in,
        output wdata_rdy, rdata, rvalid, busy, done, addr, data_out, wr, cs
    );

    modport slave (
        output req, req_wr, req_addr, req_len, wdata, data_in,
        input  wdata_rdy, rdata, rvalid, busy, done, addr, data_out, wr, cs
    );
endinterface

// File: rtl/ram_master.sv
// Burst master for a single-port synchronous-write RAM: each beat is a SETUP/ACCESS pair,
// a burst ends with one DONE cycle, and every output comes straight from a flop.
module ram_master #(
    parameter int addr_size = 4,
    parameter int word_size = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_master_if.master bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [addr_size-1:0] one = addr_size'(1);

    state_t               state_q, state_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [addr_size-1:0] cnt_q, cnt_d;
    logic                 wr_flag_q, wr_flag_d;
    logic [word_size-1:0] data_out_q, data_out_d;
    logic [word_size-1:0] rdata_q, rdata_d;
    logic                 cs_q, cs_d;
    logic                 wr_q, wr_d;
    logic                 wdata_rdy_q, wdata_rdy_d;
    logic                 rvalid_q, rvalid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wr_flag_q   <= 1'b0;
            data_out_q  <= '0;
            rdata_q     <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_rdy_q <= 1'b0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wr_flag_q   <= wr_flag_d;
            data_out_q  <= data_out_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            wdata_rdy_q <= wdata_rdy_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wr_flag_d   = wr_flag_q;
        data_out_d  = data_out_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        wdata_rdy_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d   = SETUP;
                    addr_d    = bus.req_addr;
                    cnt_d     = bus.req_len;
                    wr_flag_d = bus.req_wr;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                if (wr_flag_q) data_out_d = bus.wdata;
            end
            ACCESS: begin
                if (!wr_flag_q) begin
                    rdata_d  = bus.data_in;
                    rvalid_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SETUP;
                    cnt_d   = cnt_q - one;
                    addr_d  = addr_q + one;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops present them during that state.
        case (state_d)
            SETUP: begin
                cs_d        = 1'b1;
                wdata_rdy_d = wr_flag_d;
                busy_d      = 1'b1;
            end
            ACCESS: begin
                cs_d   = 1'b1;
                wr_d   = wr_flag_d;
                busy_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.addr      = addr_q;
    assign bus.data_out  = data_out_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.cs        = cs_q;
    assign bus.wr        = wr_q;
    assign bus.wdata_rdy = wdata_rdy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_dbg     = state_q;
endmodule
